// File: rtl/ft64_mul_sequencer.sv
// Issue/retire sequencer in front of the FT64 iterative multiplier.
// It buffers multiply ops, launches them one at a time, and returns the selected product half with its tag.
module ft64_mul_sequencer #(
    parameter int WID    = 64,
    parameter int TAGW   = 5,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [TAGW-1:0]   req_tag,
    input  logic [WID-1:0]    req_a,
    input  logic [WID-1:0]    req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TAGW-1:0]   res_tag,
    output logic [WID-1:0]    res_data,
    output logic              res_exc,
    output logic              mul_ld,
    output logic              mul_abort,
    output logic              mul_sgn,
    output logic              mul_sgnus,
    output logic [WID-1:0]    mul_a,
    output logic [WID-1:0]    mul_b,
    input  logic [2*WID-1:0]  mul_o,
    input  logic              mul_done,
    input  logic              mul_idle
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OUT,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [2:0]      op_mem_q  [QDEPTH];
    logic [2:0]      op_mem_d  [QDEPTH];
    logic [TAGW-1:0] tag_mem_q [QDEPTH];
    logic [TAGW-1:0] tag_mem_d [QDEPTH];
    logic [WID-1:0]  a_mem_q   [QDEPTH];
    logic [WID-1:0]  a_mem_d   [QDEPTH];
    logic [WID-1:0]  b_mem_q   [QDEPTH];
    logic [WID-1:0]  b_mem_d   [QDEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;

    logic [WID-1:0]  a_q, a_d;
    logic [WID-1:0]  b_q, b_d;
    logic            sgn_q, sgn_d;
    logic            sgnus_q, sgnus_d;
    logic            hi_q, hi_d;
    logic [TAGW-1:0] tag_q, tag_d;

    logic [TAGW-1:0] res_tag_q, res_tag_d;
    logic [WID-1:0]  res_data_q, res_data_d;
    logic            res_exc_q, res_exc_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            ld_c;
    logic            abort_c;

    logic [2:0]      head_op;
    logic [TAGW-1:0] head_tag;
    logic [WID-1:0]  head_a;
    logic [WID-1:0]  head_b;
    logic            head_illegal;
    logic            head_sgn;
    logic            head_sgnus;
    logic            head_hi;

    assign fifo_full  = (count_q == (PW+1)'(QDEPTH));
    assign fifo_empty = (count_q == '0);
    assign req_ready  = !fifo_full && !flush;
    assign push       = req_valid && req_ready;

    assign head_op      = op_mem_q[rd_ptr_q];
    assign head_tag     = tag_mem_q[rd_ptr_q];
    assign head_a       = a_mem_q[rd_ptr_q];
    assign head_b       = b_mem_q[rd_ptr_q];
    assign head_illegal = head_op[2] && head_op[1];
    assign head_sgn     = (head_op == 3'd0) || (head_op == 3'd3);
    assign head_sgnus   = (head_op == 3'd2) || (head_op == 3'd5);
    assign head_hi      = (head_op == 3'd3) || (head_op == 3'd4) || (head_op == 3'd5);

    // A flush empties the buffer on the same edge, so ops behind a killed op never launch.
    always_comb begin
        op_mem_d  = op_mem_q;
        tag_mem_d = tag_mem_q;
        a_mem_d   = a_mem_q;
        b_mem_d   = b_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            op_mem_d[wr_ptr_q]  = req_op;
            tag_mem_d[wr_ptr_q] = req_tag;
            a_mem_d[wr_ptr_q]   = req_a;
            b_mem_d[wr_ptr_q]   = req_b;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sgn_d      = sgn_q;
        sgnus_d    = sgnus_q;
        hi_d       = hi_q;
        tag_d      = tag_q;
        res_tag_d  = res_tag_q;
        res_data_d = res_data_q;
        res_exc_d  = res_exc_q;
        pop        = 1'b0;
        ld_c       = 1'b0;
        abort_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop = 1'b1;
                    if (head_illegal) begin
                        res_tag_d  = head_tag;
                        res_data_d = '0;
                        res_exc_d  = 1'b1;
                        state_d    = S_OUT;
                    end else begin
                        a_d     = head_a;
                        b_d     = head_b;
                        sgn_d   = head_sgn;
                        sgnus_d = head_sgnus;
                        hi_d    = head_hi;
                        tag_d   = head_tag;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (flush) begin
                    abort_c = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    ld_c    = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end
            // mul_done is also high while the multiplier sits idle, so first wait for it to go busy.
            S_WAIT_BUSY: begin
                if (flush) begin
                    abort_c = 1'b1;
                    state_d = S_DRAIN;
                end else if (!mul_idle) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (flush) begin
                    abort_c = 1'b1;
                    state_d = S_DRAIN;
                end else if (mul_done && !mul_idle) begin
                    res_tag_d  = tag_q;
                    res_data_d = hi_q ? mul_o[2*WID-1:WID] : mul_o[WID-1:0];
                    res_exc_d  = 1'b0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (flush || res_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mul_done && !mul_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            sgnus_q    <= 1'b0;
            hi_q       <= 1'b0;
            tag_q      <= '0;
            res_tag_q  <= '0;
            res_data_q <= '0;
            res_exc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sgn_q      <= sgn_d;
            sgnus_q    <= sgnus_d;
            hi_q       <= hi_d;
            tag_q      <= tag_d;
            res_tag_q  <= res_tag_d;
            res_data_q <= res_data_d;
            res_exc_q  <= res_exc_d;
        end
    end

    // Buffer storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        op_mem_q  <= op_mem_d;
        tag_mem_q <= tag_mem_d;
        a_mem_q   <= a_mem_d;
        b_mem_q   <= b_mem_d;
    end

    assign res_valid = (state_q == S_OUT);
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;
    assign res_exc   = res_exc_q;
    assign mul_ld    = ld_c && !rst;
    assign mul_abort = abort_c && !rst;
    assign mul_sgn   = sgn_q;
    assign mul_sgnus = sgnus_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;

endmodule

// File: tb/tb_ft64_mul_sequencer.sv
// Self-checking bench for ft64_mul_sequencer: a behavioural multiplier drives the back end,
// and a queue-based model of accepted ops predicts every result, launch and abort.
module tb_ft64_mul_sequencer;
    localparam int WID    = 64;
    localparam int TAGW   = 5;
    localparam int QDEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = '0;
    logic [TAGW-1:0]   req_tag = '0;
    logic [WID-1:0]    req_a = '0;
    logic [WID-1:0]    req_b = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [TAGW-1:0]   res_tag;
    logic [WID-1:0]    res_data;
    logic              res_exc;
    logic              mul_ld;
    logic              mul_abort;
    logic              mul_sgn;
    logic              mul_sgnus;
    logic [WID-1:0]    mul_a;
    logic [WID-1:0]    mul_b;
    logic [2*WID-1:0]  mul_o;
    logic              mul_done;
    logic              mul_idle;

    ft64_mul_sequencer #(.WID(WID), .TAGW(TAGW), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
        .res_exc(res_exc),
        .mul_ld(mul_ld), .mul_abort(mul_abort), .mul_sgn(mul_sgn), .mul_sgnus(mul_sgnus),
        .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o), .mul_done(mul_done), .mul_idle(mul_idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural FT64-style multiplier: abort forces a one-cycle done, done is high when idle.
    int              m_state = 0;
    int              m_cnt = 0;
    int              lat_min = 1;
    int              lat_max = 6;
    logic [127:0]    m_prod = '0;

    function automatic logic [127:0] envProduct(input logic [63:0] a, input logic [63:0] b,
                                                input logic sgn, input logic sgnus);
        logic [127:0] ea, eb;
        ea = (sgn || sgnus) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = sgn ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
        end else if (mul_abort) begin
            m_state <= 2;
        end else begin
            case (m_state)
                0: if (mul_ld) begin
                    m_state <= 1;
                    m_cnt   <= int'($urandom_range(lat_max, lat_min));
                    m_prod  <= envProduct(mul_a, mul_b, mul_sgn, mul_sgnus);
                end
                1: if (m_cnt <= 1) m_state <= 2; else m_cnt <= m_cnt - 1;
                default: m_state <= 0;
            endcase
        end
    end

    assign mul_idle = (m_state == 0);
    assign mul_done = (m_state != 1);
    assign mul_o    = (m_state == 2) ? m_prod : ~m_prod;

    // Reference result straight from the op table: signedness of each operand and which half.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        case (op)
            3'd0, 3'd3: p = sa * sb;
            3'd1, 3'd4: p = ua * ub;
            3'd2, 3'd5: p = sa * ub;
            default:    p = '0;
        endcase
        return (op >= 3'd3) ? p[127:64] : p[63:0];
    endfunction

    typedef struct {
        logic [2:0]      op;
        logic [TAGW-1:0] tag;
        logic [63:0]     a;
        logic [63:0]     b;
        logic [63:0]     data;
        logic            exc;
        bit              launched;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            e_new;
    exp_t            e_cur;
    logic [TAGW-1:0] tag_log[$];
    int              ld_cnt = 0;
    int              abort_cnt = 0;
    int              res_cnt = 0;
    logic [TAGW-1:0] last_tag = '0;
    logic [63:0]     last_data = '0;
    logic            last_exc = 1'b0;
    logic            last_sgn = 1'b0;
    logic            last_sgnus = 1'b0;

    // The op at the head of the model queue is always the one the sequencer is working on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (mul_abort) begin
                abort_cnt++;
                checkOutput("abort_only_on_flush", 128'(flush), 128'(1));
            end
            if (flush) checkOutput("req_ready_during_flush", 128'(req_ready), 128'(0));
            if (mul_ld) begin
                ld_cnt++;
                checkOutput("ld_has_pending_op", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e_cur = exp_q[0];
                    checkOutput("ld_once_per_op", 128'(e_cur.launched), 128'(0));
                    checkOutput("ld_legal_op", 128'(e_cur.exc), 128'(0));
                    checkOutput("mul_a", 128'(mul_a), 128'(e_cur.a));
                    checkOutput("mul_b", 128'(mul_b), 128'(e_cur.b));
                    checkOutput("mul_sgn", 128'(mul_sgn), 128'(e_cur.op == 3'd0 || e_cur.op == 3'd3));
                    checkOutput("mul_sgnus", 128'(mul_sgnus), 128'(e_cur.op == 3'd2 || e_cur.op == 3'd5));
                    e_cur.launched = 1'b1;
                    exp_q[0] = e_cur;
                    last_sgn = mul_sgn;
                    last_sgnus = mul_sgnus;
                end
            end
            if (res_valid) begin
                res_cnt++;
                checkOutput("res_has_pending_op", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e_cur = exp_q[0];
                    checkOutput("res_tag", 128'(res_tag), 128'(e_cur.tag));
                    checkOutput("res_data", 128'(res_data), 128'(e_cur.data));
                    checkOutput("res_exc", 128'(res_exc), 128'(e_cur.exc));
                    checkOutput("res_after_launch", 128'(e_cur.launched || e_cur.exc), 128'(1));
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (res_valid && res_ready && exp_q.size() != 0) begin
                last_tag = res_tag;
                last_data = res_data;
                last_exc = res_exc;
                tag_log.push_back(res_tag);
                void'(exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                e_new.op = req_op;
                e_new.tag = req_tag;
                e_new.a = req_a;
                e_new.b = req_b;
                e_new.data = refResult(req_op, req_a, req_b);
                e_new.exc = (req_op >= 3'd6);
                e_new.launched = 1'b0;
                exp_q.push_back(e_new);
            end
        end
    end

    bit rand_ready_en = 1'b0;
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic applyStimulus(input logic [2:0] op, input logic [TAGW-1:0] tag,
                                 input logic [63:0] a, input logic [63:0] b);
        bit accepted = 1'b0;
        req_valid = 1'b1;
        req_op = op;
        req_tag = tag;
        req_a = a;
        req_b = b;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            accepted = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        checkOutput("req_accepted", 128'(accepted), 128'(1));
    endtask

    task automatic waitIdle(input int limit);
        bit idle = 1'b0;
        for (int i = 0; i < limit && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && !res_valid;
        end
        checkOutput("drain_done", 128'(idle), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic runOne(input logic [2:0] op, input logic [TAGW-1:0] tag,
                          input logic [63:0] a, input logic [63:0] b);
        applyStimulus(op, tag, a, b);
        waitIdle(100);
    endtask

    task automatic waitLaunch(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = mul_ld;
        end
        checkOutput("launch_seen", 128'(found), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_ctrl"},
                    128'({req_ready, res_valid, res_exc, mul_ld, mul_abort, mul_sgn, mul_sgnus}),
                    128'(7'b1000000));
        checkOutput({name, "_res_tag"}, 128'(res_tag), 128'(0));
        checkOutput({name, "_res_data"}, 128'(res_data), 128'(0));
        checkOutput({name, "_mul_ab"}, {mul_a, mul_b}, 128'(0));
    endtask

    function automatic logic [63:0] randOperand();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = 64'($signed(32'($urandom_range(0, 40)) - 32'sd20));
            2: v = 64'hFFFF_FFFF_FFFF_FFFF;
            default: v = 64'h8000_0000_0000_0000;
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        int ld0, abort0, res0;
        logic [2:0] op;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset("reset");
        @(posedge clk);
        #1;

        // MUL -3 x 7: one launch, signed, result within 12 cycles of acceptance.
        ld0 = ld_cnt;
        applyStimulus(3'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            found = res_valid;
        end
        checkOutput("mul_latency", 128'(found), 128'(1));
        waitIdle(50);
        checkOutput("mul_neg_data", 128'(last_data), 128'(64'hFFFF_FFFF_FFFF_FFEB));
        checkOutput("mul_neg_exc", 128'(last_exc), 128'(0));
        checkOutput("mul_neg_ld_count", 128'(ld_cnt - ld0), 128'(1));
        checkOutput("mul_neg_sgn", 128'(last_sgn), 128'(1));

        runOne(3'd4, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("muluh_data", 128'(last_data), 128'(64'hFFFF_FFFF_FFFF_FFFE));
        runOne(3'd5, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        checkOutput("mulsuh_data", 128'(last_data), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        checkOutput("mulsuh_sgnus", 128'(last_sgnus), 128'(1));
        runOne(3'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        checkOutput("mulsu_data", 128'(last_data), 128'(64'hFFFF_FFFF_FFFF_FFFE));

        // Three back-to-back requests with the consumer stalled.
        res_ready = 1'b0;
        tag_log.delete();
        applyStimulus(3'd1, 5'd1, 64'd11, 64'd13);
        applyStimulus(3'd1, 5'd2, 64'd17, 64'd19);
        applyStimulus(3'd1, 5'd3, 64'd23, 64'd29);
        @(negedge clk);
        checkOutput("req_ready_when_full", 128'(req_ready), 128'(0));
        repeat (20) @(posedge clk);
        #1;
        res_ready = 1'b1;
        waitIdle(100);
        checkOutput("order_count", 128'(tag_log.size()), 128'(3));
        if (tag_log.size() == 3) begin
            checkOutput("order_tags", 128'({tag_log[0], tag_log[1], tag_log[2]}),
                        128'({5'd1, 5'd2, 5'd3}));
        end

        // Flush two cycles after launch with a second op still buffered.
        lat_min = 6;
        lat_max = 6;
        applyStimulus(3'd0, 5'd4, randOperand(), randOperand());
        applyStimulus(3'd0, 5'd5, randOperand(), randOperand());
        waitLaunch(found);
        ld0 = ld_cnt;
        abort0 = abort_cnt;
        res0 = res_cnt;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("flush_abort_once", 128'(abort_cnt - abort0), 128'(1));
        checkOutput("flush_no_result", 128'(res_cnt - res0), 128'(0));
        checkOutput("flush_queue_emptied", 128'(ld_cnt - ld0), 128'(0));
        checkOutput("flush_ready_after", 128'(req_ready), 128'(1));
        lat_min = 1;
        lat_max = 6;
        runOne(3'd0, 5'd11, 64'd6, 64'd7);
        checkOutput("post_flush_data", 128'(last_data), 128'(42));
        checkOutput("post_flush_tag", 128'(last_tag), 128'(11));

        // Illegal op returns an exception without touching the multiplier.
        ld0 = ld_cnt;
        runOne(3'd7, 5'd9, randOperand(), randOperand());
        checkOutput("illegal_exc", 128'(last_exc), 128'(1));
        checkOutput("illegal_data", 128'(last_data), 128'(0));
        checkOutput("illegal_tag", 128'(last_tag), 128'(9));
        checkOutput("illegal_no_ld", 128'(ld_cnt - ld0), 128'(0));

        // Reset in the middle of an operation.
        applyStimulus(3'd1, 5'd6, randOperand(), randOperand());
        waitLaunch(found);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset("reset_midop");
        @(posedge clk);
        #1;

        // Randomised traffic with a stalling consumer and occasional flushes.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
            op = 3'($urandom_range(0, 7));
            applyStimulus(op, n[TAGW-1:0], randOperand(), randOperand());
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        waitIdle(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
